qerv_dbus_resp: RTL and testbench

QERV_DBUS_RESP -- requirements
Module: qerv_dbus_resp

---
 rtl/qerv_dbus_resp.sv | 115 +++++++++++
 tb/tb_qerv_dbus_resp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qerv_dbus_resp.sv
// rtl/qerv_dbus_resp.sv - data-bus responder bridging a Wishbone-style request to a synchronous SRAM
// One request in flight; configurable wait cycles before the ack pulse.
module qerv_dbus_resp #(
  parameter int AW   = 10,
  parameter int WAIT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wb_cyc,
  input  logic          i_wb_we,
  input  logic [31:0]   i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_wen,
  output logic          o_mem_ren,
  input  logic [31:0]   i_mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_MEM, S_WAIT, S_ACK, S_COOL} state_t;

  localparam logic [3:0] WAIT_M1 = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_adr;
  logic [31:0]   r_dat;
  logic [3:0]    r_sel;
  logic          r_we;
  logic          r_inr;
  logic [3:0]    r_cnt;
  logic          r_after_mem;
  logic [31:0]   r_hold;
  logic [31:0]   r_rdt;

  logic          w_oor;
  logic          w_accept;
  logic          w_strobe_ok;
  logic [31:0]   w_cap;
  logic [31:0]   w_ack_data;
  logic          w_unused;

  assign w_unused    = ^i_wb_adr[1:0];
  assign w_oor       = |(i_wb_adr >> (AW + 2));
  assign w_accept    = (r_state == S_IDLE) && i_wb_cyc;
  assign w_strobe_ok = (r_state == S_MEM) && r_inr;

  // SRAM data is only meaningful the cycle after an in-range load strobe.
  assign w_cap      = (!r_we && r_inr) ? i_mem_rdata : 32'd0;
  // With no wait cycles the ack lands in the capture cycle, so bypass the hold register.
  assign w_ack_data = r_after_mem ? w_cap : r_hold;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_wb_cyc) w_next = S_MEM;
      S_MEM: begin
        if (!i_wb_cyc)      w_next = S_IDLE;
        else if (WAIT == 0) w_next = S_ACK;
        else                w_next = S_WAIT;
      end
      S_WAIT: begin
        if (!i_wb_cyc)       w_next = S_IDLE;
        else if (r_cnt == 0) w_next = S_ACK;
      end
      S_ACK:   w_next = i_wb_cyc ? S_COOL : S_IDLE;
      S_COOL:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_inr       <= 1'b0;
      r_cnt       <= '0;
      r_after_mem <= 1'b0;
      r_hold      <= '0;
      r_rdt       <= '0;
    end else begin
      r_state     <= w_next;
      r_after_mem <= (r_state == S_MEM);
      if (w_accept) begin
        r_adr <= i_wb_adr[AW+1:2];
        r_dat <= i_wb_dat;
        r_sel <= i_wb_sel;
        r_we  <= i_wb_we;
        r_inr <= !w_oor;
      end
      if (r_state == S_MEM)
        r_cnt <= WAIT_M1;
      else if (r_state == S_WAIT && r_cnt != 0)
        r_cnt <= r_cnt - 4'd1;
      if (r_after_mem)
        r_hold <= w_cap;
      if (o_wb_ack)
        r_rdt <= w_ack_data;
    end
  end

  assign o_wb_ack    = (r_state == S_ACK) && i_wb_cyc;
  assign o_wb_rdt    = o_wb_ack ? w_ack_data : r_rdt;
  assign o_mem_ren   = w_strobe_ok && !r_we;
  assign o_mem_wen   = (w_strobe_ok && r_we) ? r_sel : 4'b0000;
  assign o_mem_addr  = r_adr;
  assign o_mem_wdata = r_dat;

endmodule

// File: tb/tb_qerv_dbus_resp.sv
// tb/tb_qerv_dbus_resp.sv - self-checking bench for qerv_dbus_resp
// Three instances (WAIT = 0, 1, 3) each backed by its own SRAM model and word-level reference memory.
module tb_qerv_dbus_resp;
  localparam int AW = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cyc   [3];
  logic            we    [3];
  logic [31:0]     adr   [3];
  logic [31:0]     dat   [3];
  logic [3:0]      sel   [3];
  logic [31:0]     rdt   [3];
  logic            ack   [3];
  logic [AW-1:0]   maddr [3];
  logic [31:0]     mwdat [3];
  logic [3:0]      mwen  [3];
  logic            mren  [3];
  logic [31:0]     mrdat [3];
  logic [31:0]     sram  [3][1024];
  logic [31:0]     ref_mem [3][1024];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    qerv_dbus_resp #(.AW(AW), .WAIT(g == 0 ? 0 : (g == 1 ? 1 : 3))) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc[g]), .i_wb_we(we[g]),
      .i_wb_adr(adr[g]), .i_wb_dat(dat[g]), .i_wb_sel(sel[g]),
      .o_wb_rdt(rdt[g]), .o_wb_ack(ack[g]), .o_mem_addr(maddr[g]),
      .o_mem_wdata(mwdat[g]), .o_mem_wen(mwen[g]), .o_mem_ren(mren[g]),
      .i_mem_rdata(mrdat[g])
    );
  end

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (mren[g]) mrdat[g] <= sram[g][maddr[g]];
      for (int b = 0; b < 4; b++)
        if (mwen[g][b]) sram[g][maddr[g]][8*b +: 8] <= mwdat[g][8*b +: 8];
    end
  end

  typedef struct {
    int          strobe_seen;
    logic        ren_v;
    logic [3:0]  wen_v;
    logic [31:0] addr_v;
    int          ack_at;
    int          acks;
    logic [31:0] rdt_v;
    int          stray;
    logic        hold_ok;
  } res_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        e_ren;
    logic [3:0]  e_wen;
    logic [31:0] e_rdt;
  } vec_t;

  function automatic int waits(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: word-addressed memory with byte-lane merge; out-of-range touches nothing and reads 0.
  task automatic model(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic e_ren, output logic [3:0] e_wen,
                       output logic [31:0] e_rdt);
    logic inr;
    int   word;
    inr   = (a >> (AW + 2)) == 0;
    word  = int'((a >> 2) % (1 << AW));
    e_ren = inr && !w;
    e_wen = (inr && w) ? s : 4'b0000;
    e_rdt = (inr && !w) ? ref_mem[k][word] : 32'd0;
    if (inr && w)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[k][word][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic run_txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output res_t r);
    r = '{0, 1'b0, 4'b0, 32'd0, -1, 0, 32'd0, 0, 1'b0};
    cyc[k] = 1'b1; we[k] = w; adr[k] = a; dat[k] = d; sel[k] = s;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        r.strobe_seen = 1;
        r.ren_v  = mren[k];
        r.wen_v  = mwen[k];
        r.addr_v = 32'(maddr[k]);
      end else if (mren[k] || mwen[k] != 4'b0000) begin
        r.stray++;
      end
      if (ack[k]) begin
        r.acks++;
        if (r.ack_at < 0) begin r.ack_at = i; r.rdt_v = rdt[k]; end
      end
      if (r.ack_at > 0 && i == r.ack_at + 1) begin
        r.hold_ok = (rdt[k] === r.rdt_v);
        cyc[k] = 1'b0;
        we[k] = $urandom_range(0, 1); adr[k] = $urandom; dat[k] = $urandom; sel[k] = 4'($urandom);
      end
    end
    cyc[k] = 1'b0;
  endtask

  task automatic txn_checked(input string nm, input int k, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
    res_t        r;
    logic        e_ren;
    logic [3:0]  e_wen;
    logic [31:0] e_rdt;
    model(k, w, a, d, s, e_ren, e_wen, e_rdt);
    run_txn(k, w, a, d, s, r);
    chk({nm, ".ren"},   64'(r.ren_v), 64'(e_ren));
    chk({nm, ".wen"},   64'(r.wen_v), 64'(e_wen));
    chk({nm, ".addr"},  64'(r.addr_v), 64'((a >> 2) % (1 << AW)));
    chk({nm, ".ackat"}, 64'(r.ack_at), 64'(2 + waits(k)));
    chk({nm, ".acks"},  64'(r.acks), 64'd1);
    chk({nm, ".rdt"},   64'(r.rdt_v), 64'(e_rdt));
    chk({nm, ".stray"}, 64'(r.stray), 64'd0);
    chk({nm, ".hold"},  64'(r.hold_ok), 64'd1);
  endtask

  initial begin
    vec_t        tbl[9];
    res_t        r;
    logic        e_ren;
    logic [3:0]  e_wen;
    logic [31:0] e_rdt;
    logic [15:0] smask;
    logic [15:0] amask;
    int          acks_after;
    logic [31:0] a;

    tbl[0] = '{1'b1, 32'h0000_0010, 32'h0000_0000, 4'hF, 1'b0, 4'hF, 32'h0};
    tbl[1] = '{1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'h3, 1'b0, 4'h3, 32'h0};
    tbl[2] = '{1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'h0, 32'h0000_1234};
    tbl[3] = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 1'b0, 4'h0, 32'h0};
    tbl[4] = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 1'b0, 4'h0, 32'h0};
    tbl[5] = '{1'b1, 32'h0000_1010, 32'h5555_5555, 4'hF, 1'b0, 4'h0, 32'h0};
    tbl[6] = '{1'b1, 32'h0000_0013, 32'hCAFE_0000, 4'hC, 1'b0, 4'hC, 32'h0};
    tbl[7] = '{1'b0, 32'h0000_0011, 32'h0,         4'h0, 1'b1, 4'h0, 32'hCAFE_1234};
    tbl[8] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 1'b0, 4'h0, 32'h0};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc[k] = 1'b0; we[k] = 1'b0; adr[k] = 32'd0; dat[k] = 32'd0; sel[k] = 4'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_outs%0d", k),
          {rdt[k], ack[k], mren[k], mwen[k], 10'(maddr[k]), 17'd0}, 64'd0);
    for (int k = 0; k < 3; k++) chk($sformatf("reset_wdata%0d", k), 64'(mwdat[k]), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++)
        txn_checked($sformatf("init%0d_%0d", k, w), k, 1'b1, 32'(w * 4), $urandom, 4'hF);

    for (int i = 0; i < 9; i++) begin
      model(1, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, e_ren, e_wen, e_rdt);
      run_txn(1, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, r);
      chk($sformatf("tbl%0d.ren", i),   64'(r.ren_v), 64'(tbl[i].e_ren));
      chk($sformatf("tbl%0d.wen", i),   64'(r.wen_v), 64'(tbl[i].e_wen));
      chk($sformatf("tbl%0d.ackat", i), 64'(r.ack_at), 64'd3);
      chk($sformatf("tbl%0d.acks", i),  64'(r.acks), 64'd1);
      chk($sformatf("tbl%0d.rdt", i),   64'(r.rdt_v), 64'(tbl[i].e_rdt));
      chk($sformatf("tbl%0d.stray", i), 64'(r.stray), 64'd0);
    end
    chk("tbl.store_addr4", 64'(sram[1][4]), 64'hCAFE_1234);

    txn_checked("w0_store_beef", 0, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF);
    run_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, r);
    chk("w0_load.ren",   64'(r.ren_v), 64'd1);
    chk("w0_load.ackat", 64'(r.ack_at), 64'd2);
    chk("w0_load.acks",  64'(r.acks), 64'd1);
    chk("w0_load.rdt",   64'(r.rdt_v), 64'hDEAD_BEEF);
    txn_checked("w3_oor_load", 2, 1'b0, 32'h0000_1000, 32'h0, 4'hF);

    // cyc held high past the ack: next accept must wait out the cool-down cycle
    smask = '0; amask = '0;
    cyc[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h10; dat[1] = 32'h0; sel[1] = 4'h0;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #1;
      if (mren[1]) smask[i] = 1'b1;
      if (ack[1]) amask[i] = 1'b1;
      if (i == 9) cyc[1] = 1'b0;
    end
    chk("b2b.strobes", 64'(smask), 64'h0042);
    chk("b2b.acks",    64'(amask), 64'h0108);

    // cyc dropped in WAIT after a store strobe: no ack, store still lands
    model(2, 1'b1, 32'h1C, 32'h1111_2222, 4'hF, e_ren, e_wen, e_rdt);
    cyc[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h1C; dat[2] = 32'h1111_2222; sel[2] = 4'hF;
    @(posedge clk); #1;
    chk("abort.wen", 64'(mwen[2]), 64'hF);
    @(posedge clk); #1;
    cyc[2] = 1'b0;
    acks_after = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack[2]) acks_after++;
    end
    chk("abort.noack", 64'(acks_after), 64'd0);
    txn_checked("abort.reload", 2, 1'b0, 32'h1C, 32'h0, 4'h0);

    // asynchronous reset in the MEM cycle
    cyc[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h14; dat[1] = 32'h7777_7777; sel[1] = 4'hF;
    @(posedge clk); #1;
    chk("rstmid.ren_before", 64'(mren[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.ren",   64'(mren[1]), 64'd0);
    chk("rstmid.addr",  64'(maddr[1]), 64'd0);
    chk("rstmid.wdata", 64'(mwdat[1]), 64'd0);
    chk("rstmid.rdt",   64'(rdt[1]), 64'd0);
    chk("rstmid.ack",   64'(ack[1]), 64'd0);
    @(negedge clk); cyc[1] = 1'b0; rst_n = 1'b1;
    acks_after = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack[1]) acks_after++;
    end
    chk("rstmid.noack", 64'(acks_after), 64'd0);

    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) a = $urandom | 32'h0000_1000;
      else a = 32'($urandom_range(0, 63));
      txn_checked($sformatf("rnd%0d", n), k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
